// File: rtl/noc_inject_packer.sv
// Packs IN_WIDTH user words into TDATA_WIDTH router injection beats, first word in the lowest lane.
// The packet header (dest/id) is taken from the first word of each packet.
module noc_inject_packer #(
    parameter int IN_WIDTH    = 32,
    parameter int TDATA_WIDTH = 128,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4
) (
    input  logic                   clk_usr,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [IN_WIDTH-1:0]    s_data,
    input  logic                   s_last,
    input  logic [TDEST_WIDTH-1:0] s_dest,
    input  logic [TID_WIDTH-1:0]   s_id,
    output logic                   axis_in_tvalid,
    input  logic                   axis_in_tready,
    output logic [TDATA_WIDTH-1:0] axis_in_tdata,
    output logic                   axis_in_tlast,
    output logic [TID_WIDTH-1:0]   axis_in_tid,
    output logic [TDEST_WIDTH-1:0] axis_in_tdest,
    output logic [15:0]            beat_count,
    output logic [15:0]            pkt_count
);

    localparam int RATIO  = TDATA_WIDTH / IN_WIDTH;
    localparam int LANE_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0]      lane_r;
    logic                   in_pkt_r;
    logic [TDATA_WIDTH-1:0] asm_r;
    logic [TDEST_WIDTH-1:0] pkt_dest_r;
    logic [TID_WIDTH-1:0]   pkt_id_r;

    logic                   word_xfer_s;
    logic                   beat_xfer_s;
    logic                   complete_s;
    logic [TDATA_WIDTH-1:0] merged_s;
    logic [TDEST_WIDTH-1:0] hdr_dest_s;
    logic [TID_WIDTH-1:0]   hdr_id_s;

    // A full output register may be refilled in the same cycle it is drained.
    assign s_ready     = !axis_in_tvalid || axis_in_tready;
    assign word_xfer_s = s_valid && s_ready;
    assign beat_xfer_s = axis_in_tvalid && axis_in_tready;
    assign complete_s  = word_xfer_s && ((lane_r == LAST_LANE) || s_last);
    assign hdr_dest_s  = in_pkt_r ? pkt_dest_r : s_dest;
    assign hdr_id_s    = in_pkt_r ? pkt_id_r : s_id;

    // Assembly register with the incoming word dropped into the current lane.
    always_comb begin
        merged_s = asm_r;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_r == LANE_W'(k)) begin
                merged_s[k*IN_WIDTH +: IN_WIDTH] = s_data;
            end else begin
                merged_s[k*IN_WIDTH +: IN_WIDTH] = asm_r[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Word assembly, header capture and packet tracking.
    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            lane_r     <= {LANE_W{1'b0}};
            in_pkt_r   <= 1'b0;
            asm_r      <= {TDATA_WIDTH{1'b0}};
            pkt_dest_r <= {TDEST_WIDTH{1'b0}};
            pkt_id_r   <= {TID_WIDTH{1'b0}};
        end else if (word_xfer_s) begin
            if (!in_pkt_r) begin
                pkt_dest_r <= s_dest;
                pkt_id_r   <= s_id;
            end
            in_pkt_r <= !s_last;
            if (complete_s) begin
                lane_r <= {LANE_W{1'b0}};
                asm_r  <= {TDATA_WIDTH{1'b0}};
            end else begin
                lane_r <= lane_r + {{(LANE_W-1){1'b0}}, 1'b1};
                asm_r  <= merged_s;
            end
        end
    end

    // Output beat register: loads on a completing word, otherwise drains on acceptance.
    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            axis_in_tvalid <= 1'b0;
            axis_in_tdata  <= {TDATA_WIDTH{1'b0}};
            axis_in_tlast  <= 1'b0;
            axis_in_tid    <= {TID_WIDTH{1'b0}};
            axis_in_tdest  <= {TDEST_WIDTH{1'b0}};
        end else if (complete_s) begin
            axis_in_tvalid <= 1'b1;
            axis_in_tdata  <= merged_s;
            axis_in_tlast  <= s_last;
            axis_in_tid    <= hdr_id_s;
            axis_in_tdest  <= hdr_dest_s;
        end else if (beat_xfer_s) begin
            axis_in_tvalid <= 1'b0;
        end
    end

    // Wrapping beat and packet counters.
    always_ff @(posedge clk_usr or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= 16'd0;
            pkt_count  <= 16'd0;
        end else if (beat_xfer_s) begin
            beat_count <= beat_count + 16'd1;
            if (axis_in_tlast) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_inject_packer.sv
// Scoreboard bench for noc_inject_packer: a packet-level model predicts beats, a monitor compares them.
module tb_noc_inject_packer;

    localparam int IW = 32;
    localparam int TW = 128;
    localparam int RATIO = TW / IW;

    typedef struct {
        logic [TW-1:0] data;
        logic          last;
        logic [1:0]    id;
        logic [3:0]    dest;
    } beat_t;

    logic          clk_usr;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] s_data;
    logic          s_last;
    logic [3:0]    s_dest;
    logic [1:0]    s_id;
    logic          axis_in_tvalid;
    logic          axis_in_tready;
    logic [TW-1:0] axis_in_tdata;
    logic          axis_in_tlast;
    logic [1:0]    axis_in_tid;
    logic [3:0]    axis_in_tdest;
    logic [15:0]   beat_count;
    logic [15:0]   pkt_count;

    noc_inject_packer #(.IN_WIDTH(IW), .TDATA_WIDTH(TW), .TID_WIDTH(2), .TDEST_WIDTH(4)) dut (
        .clk_usr(clk_usr), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .s_dest(s_dest), .s_id(s_id),
        .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
        .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
        .beat_count(beat_count), .pkt_count(pkt_count)
    );

    initial clk_usr = 1'b0;
    always #5 clk_usr = ~clk_usr;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_beats = 0;
    int exp_pkts = 0;
    int sent_last = 0;
    bit lat_pend = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    logic [IW-1:0] m_words[$];
    bit m_in_pkt = 0;
    logic [3:0] m_dest;
    logic [1:0] m_id;

    task automatic check(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference model: collect a packet's words, emit a beat every RATIO words or at packet end.
    task automatic model_word(input logic [IW-1:0] d, input logic l, input logic [3:0] de,
                              input logic [1:0] id, output bit done);
        beat_t b;
        done = 0;
        if (!m_in_pkt) begin
            m_dest = de;
            m_id = id;
        end
        m_words.push_back(d);
        m_in_pkt = !l;
        if (l || m_words.size() == RATIO) begin
            b.data = '0;
            foreach (m_words[i]) b.data = b.data | (TW'(m_words[i]) << (IW * i));
            b.last = l;
            b.id = m_id;
            b.dest = m_dest;
            exp_q.push_back(b);
            exp_beats++;
            if (l) exp_pkts++;
            m_words.delete();
            done = 1;
        end
    endtask

    // Input monitor: feeds accepted words to the model and checks one-cycle beat latency.
    always @(negedge clk_usr) begin
        bit done;
        if (!rst_n) begin
            m_words.delete();
            m_in_pkt = 0;
            exp_q.delete();
            exp_beats = 0;
            exp_pkts = 0;
            lat_pend = 0;
        end else begin
            if (lat_pend) check("latency_tvalid", axis_in_tvalid, 1'b1);
            lat_pend = 0;
            if (s_valid && s_ready) begin
                model_word(s_data, s_last, s_dest, s_id, done);
                lat_pend = done;
            end
        end
    end

    // Output monitor: every accepted beat is logged and compared with the oldest prediction.
    always @(negedge clk_usr) begin
        beat_t a;
        beat_t e;
        if (rst_n && axis_in_tvalid && axis_in_tready) begin
            a.data = axis_in_tdata;
            a.last = axis_in_tlast;
            a.id = axis_in_tid;
            a.dest = axis_in_tdest;
            got_q.push_back(a);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got tdata %h, expected no beat", a.data);
            end else begin
                e = exp_q.pop_front();
                check("beat_tdata", a.data, e.data);
                check("beat_tlast", a.last, e.last);
                check("beat_tid", a.id, e.id);
                check("beat_tdest", a.dest, e.dest);
            end
        end
    end

    task automatic send_word(input logic [IW-1:0] d, input logic l, input logic [3:0] de, input logic [1:0] id);
        bit ok = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        s_dest = de;
        s_id = id;
        if (l) sent_last++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_usr);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL word_accept_timeout: got s_ready 0 for 200 cycles, expected 1");
        end
        @(posedge clk_usr);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_usr);
            if (exp_q.size() == 0 && !axis_in_tvalid) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d beats outstanding, expected 0", nm, exp_q.size());
        end
        @(posedge clk_usr);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_tvalid"}, axis_in_tvalid, 1'b0);
        check({nm, "_tdata"}, axis_in_tdata, '0);
        check({nm, "_tlast"}, axis_in_tlast, 1'b0);
        check({nm, "_tid"}, axis_in_tid, 2'd0);
        check({nm, "_tdest"}, axis_in_tdest, 4'd0);
        check({nm, "_beat_count"}, beat_count, 16'd0);
        check({nm, "_pkt_count"}, pkt_count, 16'd0);
        check({nm, "_s_ready"}, s_ready, 1'b1);
    endtask

    initial begin
        int base;
        logic [IW-1:0] w[8];
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        s_dest = 4'd0;
        s_id = 2'd0;
        axis_in_tready = 1'b0;
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk_usr);
        #1;
        rst_n = 1'b1;
        @(posedge clk_usr);
        #1;

        // Full two-beat packet.
        axis_in_tready = 1'b1;
        base = got_q.size();
        for (int k = 1; k <= 8; k++) send_word(32'h11111111 * k, k == 8, 4'd5, 2'd2);
        drain("full");
        check("full_nbeats", got_q.size() - base, 2);
        check("full_b1_tdata", got_q[base].data, 128'h44444444_33333333_22222222_11111111);
        check("full_b1_tlast", got_q[base].last, 1'b0);
        check("full_b2_tdata", got_q[base+1].data, 128'h88888888_77777777_66666666_55555555);
        check("full_b2_tlast", got_q[base+1].last, 1'b1);
        check("full_b2_hdr", {got_q[base+1].dest, got_q[base+1].id}, {4'd5, 2'd2});
        check("full_beat_count", beat_count, 16'd2);
        check("full_pkt_count", pkt_count, 16'd1);

        // Six-word packet: second beat half filled.
        base = got_q.size();
        for (int k = 0; k < 6; k++) send_word($urandom, k == 5, 4'd1, 2'd3);
        drain("partial");
        check("partial_nbeats", got_q.size() - base, 2);
        check("partial_upper_zero", got_q[base+1].data[127:64], 64'd0);
        check("partial_tlast", got_q[base+1].last, 1'b1);
        check("partial_beat_count", beat_count, 16'(exp_beats));

        // Backpressure with a beat pending and the next word waiting.
        for (int k = 0; k < 6; k++) w[k] = 32'hA0000001 + k;
        axis_in_tready = 1'b0;
        base = got_q.size();
        for (int k = 0; k < 4; k++) send_word(w[k], 1'b0, 4'd6, 2'd1);
        s_valid = 1'b1;
        s_data = w[4];
        s_last = 1'b0;
        repeat (5) begin
            @(negedge clk_usr);
            check("bp_s_ready", s_ready, 1'b0);
            check("bp_tvalid", axis_in_tvalid, 1'b1);
            check("bp_tdata", axis_in_tdata, {w[3], w[2], w[1], w[0]});
            check("bp_hdr", {axis_in_tlast, axis_in_tdest, axis_in_tid}, {1'b0, 4'd6, 2'd1});
        end
        @(posedge clk_usr);
        #1;
        axis_in_tready = 1'b1;
        send_word(w[4], 1'b0, 4'd6, 2'd1);
        send_word(w[5], 1'b1, 4'd6, 2'd1);
        drain("bp");
        check("bp_nbeats", got_q.size() - base, 2);
        check("bp_b2_tdata", got_q[base+1].data, {64'd0, w[5], w[4]});

        // Header changes after the first word are ignored.
        base = got_q.size();
        for (int k = 0; k < 8; k++) begin
            if (k >= 1 && k <= 3) send_word($urandom, 1'b0, 4'd9, 2'd1);
            else send_word($urandom, k == 7, 4'd3, 2'd3);
        end
        drain("hdr");
        check("hdr_nbeats", got_q.size() - base, 2);
        for (int b = 0; b < 2; b++) check("hdr_fields", {got_q[base+b].dest, got_q[base+b].id}, {4'd3, 2'd3});
        check("hdr_pkt_count", pkt_count, 16'(exp_pkts));

        // Reset in the middle of a packet.
        for (int k = 0; k < 3; k++) send_word(32'hBAD00000 + k, 1'b0, 4'd2, 2'd2);
        rst_n = 1'b0;
        sent_last = 0;
        #2;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk_usr);
        #1;
        rst_n = 1'b1;
        @(posedge clk_usr);
        #1;
        base = got_q.size();
        send_word(32'hCAFEF00D, 1'b1, 4'd7, 2'd1);
        drain("postrst");
        check("postrst_nbeats", got_q.size() - base, 1);
        check("postrst_tdata", got_q[base].data, {96'd0, 32'hCAFEF00D});
        check("postrst_hdr", {got_q[base].last, got_q[base].dest, got_q[base].id}, {1'b1, 4'd7, 2'd1});
        check("postrst_counts", {beat_count, pkt_count}, {16'd1, 16'd1});

        // Random soak: random valid gaps, tready and packet lengths.
        begin
            int words_left = 10000;
            int pkt_rem = 0;
            int cyc = 0;
            bit acc;
            while ((words_left > 0 || pkt_rem > 0 || s_valid) && cyc < 60000) begin
                @(negedge clk_usr);
                acc = s_valid && s_ready;
                @(posedge clk_usr);
                #1;
                cyc++;
                if (acc) s_valid = 1'b0;
                axis_in_tready = ($urandom_range(0, 9) < 7);
                if (!s_valid && (pkt_rem > 0 || words_left > 0) && $urandom_range(0, 3) != 0) begin
                    if (pkt_rem == 0) pkt_rem = $urandom_range(1, 12);
                    s_data = $urandom;
                    s_dest = 4'($urandom_range(0, 15));
                    s_id = 2'($urandom_range(0, 3));
                    s_last = (pkt_rem == 1);
                    if (s_last) sent_last++;
                    pkt_rem--;
                    if (words_left > 0) words_left--;
                    s_valid = 1'b1;
                end
            end
            n_cmp++;
            if (cyc >= 60000) begin
                n_bad++;
                $display("FAIL soak_timeout: got %0d words unsent after %0d cycles, expected 0", words_left, cyc);
            end
            axis_in_tready = 1'b1;
            drain("soak");
            check("soak_pkt_count", pkt_count, 16'(sent_last));
            check("soak_beat_count", beat_count, 16'(exp_beats));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
